// File: rtl/exec_unit_m_pkg.sv
// rtl/exec_unit_m_pkg.sv - opcode/funct encodings and FSM state type for the execute stage
package exec_unit_m_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} exec_state_t;

endpackage

// File: rtl/exec_unit_m_if.sv
// rtl/exec_unit_m_if.sv - operand-in / result-out handshake bundle of the execute stage
//   master: decode side driving operands and consuming results
//   slave : execute unit
interface exec_unit_m_if #(parameter int XLEN = 32) ();
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] rd_data;
    logic [XLEN-1:0] mem_addr;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            illegal;
    logic            busy;

    modport master (
        output in_valid, opcode, funct3, funct7, pc, imm, rs1_val, rs2_val, out_ready,
        input  in_ready, out_valid, rd_data, mem_addr, br_taken, br_target, illegal, busy
    );

    modport slave (
        input  in_valid, opcode, funct3, funct7, pc, imm, rs1_val, rs2_val, out_ready,
        output in_ready, out_valid, rd_data, mem_addr, br_taken, br_target, illegal, busy
    );
endinterface

// File: rtl/exec_unit_m_div_iter.sv
// rtl/exec_unit_m_div_iter.sv - restoring divider, one quotient bit per cycle
//   start     : load operands (one-cycle pulse)
//   dividend/divisor, signed_op, rem_sel : operation select, sampled on start
//   done      : result valid for one cycle, XLEN cycles after start
//   result    : quotient or remainder
module div_iter #(parameter int XLEN = 32) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            signed_op,
    input  logic            rem_sel,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN + 1);

    logic            run;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] q, r, d, a_raw;
    logic            neg_q, neg_r, div0, rsel;
    logic            a_neg, b_neg;
    logic [XLEN:0]   trial, diff;

    assign a_neg = signed_op & dividend[XLEN-1];
    assign b_neg = signed_op & divisor[XLEN-1];
    assign trial = {r, q[XLEN-1]};
    assign diff  = trial - {1'b0, d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run   <= 1'b0;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            d     <= '0;
            a_raw <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            div0  <= 1'b0;
            rsel  <= 1'b0;
        end else if (start) begin
            run   <= 1'b1;
            cnt   <= CW'(XLEN);
            q     <= a_neg ? -dividend : dividend;
            d     <= b_neg ? -divisor : divisor;
            r     <= '0;
            a_raw <= dividend;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            div0  <= (divisor == '0);
            rsel  <= rem_sel;
        end else if (run) begin
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
                if (!diff[XLEN]) begin
                    r <= diff[XLEN-1:0];
                    q <= {q[XLEN-2:0], 1'b1};
                end else begin
                    r <= trial[XLEN-1:0];
                    q <= {q[XLEN-2:0], 1'b0};
                end
            end else begin
                run <= 1'b0;
            end
        end
    end

    assign done = run && (cnt == '0);

    // MIN / -1 needs no special path: |MIN| is MIN as an unsigned magnitude,
    // the quotient sign cancels and the remainder comes out 0.
    always_comb begin
        result = '0;
        if (div0)
            result = rsel ? a_raw : '1;
        else if (rsel)
            result = neg_r ? -r : r;
        else
            result = neg_q ? -q : q;
    end
endmodule

// File: rtl/exec_unit_m.sv
// rtl/exec_unit_m.sv - RV32I/RV32M execute stage with registered, handshaked result
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of exec_unit_m_if (operands in, result/branch/illegal/busy out)
module exec_unit_m
    import exec_unit_m_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    exec_unit_m_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    exec_state_t     state_q;
    logic            out_valid_q, taken_q, ill_q;
    logic [XLEN-1:0] rd_q, addr_q, tgt_q, pc4_q;

    logic            in_ready_w, accept;
    logic [XLEN-1:0] op_b, agen, pc4, alu_res;
    logic [SHW-1:0]  shamt;
    logic            lt_s, lt_u, eq, cond;
    logic [XLEN-1:0] n_rd, n_addr, n_tgt;
    logic            n_taken, n_ill, is_mul, is_div;

    logic              a_sgn, b_sgn;
    logic [2*XLEN-1:0] a_ext, b_ext, mul_full;
    logic [XLEN-1:0]   mul_sel;
    logic [XLEN-1:0]   mul_pipe [MUL_LAT];
    logic [MUL_LAT-1:0] mul_v;

    logic            div_done;
    logic [XLEN-1:0] div_result;

    assign in_ready_w = !rst && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept     = bus.in_valid && in_ready_w;

    assign pc4  = bus.pc + XLEN'(4);
    assign agen = bus.rs1_val + bus.imm;

    always_comb begin
        op_b  = (bus.opcode == OPC_OP || bus.opcode == OPC_BRANCH) ? bus.rs2_val : bus.imm;
        shamt = op_b[SHW-1:0];
        lt_s  = $signed(bus.rs1_val) < $signed(op_b);
        lt_u  = bus.rs1_val < op_b;
        eq    = bus.rs1_val == op_b;

        case (bus.funct3)
            F3_ADD:  alu_res = (bus.opcode == OPC_OP && bus.funct7[5]) ?
                               bus.rs1_val - op_b : bus.rs1_val + op_b;
            F3_SLL:  alu_res = bus.rs1_val << shamt;
            F3_SLT:  alu_res = XLEN'(lt_s);
            F3_SLTU: alu_res = XLEN'(lt_u);
            F3_XOR:  alu_res = bus.rs1_val ^ op_b;
            F3_SR:   alu_res = bus.funct7[5] ? XLEN'($signed(bus.rs1_val) >>> shamt) :
                                               bus.rs1_val >> shamt;
            F3_OR:   alu_res = bus.rs1_val | op_b;
            default: alu_res = bus.rs1_val & op_b;
        endcase

        case (bus.funct3)
            F3_BEQ:  cond = eq;
            F3_BNE:  cond = !eq;
            F3_BLT:  cond = lt_s;
            F3_BGE:  cond = !lt_s;
            F3_BLTU: cond = lt_u;
            F3_BGEU: cond = !lt_u;
            default: cond = 1'b0;
        endcase
    end

    // Decode into the next-result bundle; illegal paths leave rd/addr/taken at 0.
    always_comb begin
        n_rd    = '0;
        n_addr  = '0;
        n_taken = 1'b0;
        n_tgt   = pc4;
        n_ill   = 1'b0;
        is_mul  = 1'b0;
        is_div  = 1'b0;
        case (bus.opcode)
            OPC_LUI:   n_rd = bus.imm;
            OPC_AUIPC: n_rd = bus.pc + bus.imm;
            OPC_JAL: begin
                n_rd    = pc4;
                n_taken = 1'b1;
                n_tgt   = bus.pc + bus.imm;
            end
            OPC_JALR: begin
                if (bus.funct3 != 3'b000) begin
                    n_ill = 1'b1;
                end else begin
                    n_rd    = pc4;
                    n_taken = 1'b1;
                    n_tgt   = {agen[XLEN-1:1], 1'b0};
                end
            end
            OPC_BRANCH: begin
                if (bus.funct3 == 3'b010 || bus.funct3 == 3'b011) begin
                    n_ill = 1'b1;
                end else begin
                    n_taken = cond;
                    if (cond) n_tgt = bus.pc + bus.imm;
                end
            end
            OPC_LOAD: begin
                if (bus.funct3 == 3'b011 || bus.funct3 == 3'b110 || bus.funct3 == 3'b111)
                    n_ill = 1'b1;
                else
                    n_addr = agen;
            end
            OPC_STORE: begin
                if (bus.funct3[2] || bus.funct3 == 3'b011) begin
                    n_ill = 1'b1;
                end else begin
                    n_addr = agen;
                    n_rd   = bus.rs2_val;
                end
            end
            OPC_OP_IMM: begin
                if ((bus.funct3 == F3_SLL && bus.funct7 != F7_BASE) ||
                    (bus.funct3 == F3_SR && bus.funct7 != F7_BASE && bus.funct7 != F7_ALT))
                    n_ill = 1'b1;
                else
                    n_rd = alu_res;
            end
            OPC_OP: begin
                if (bus.funct7 == F7_MEXT) begin
                    is_mul = !bus.funct3[2];
                    is_div = bus.funct3[2];
                end else if (bus.funct7 == F7_BASE ||
                             (bus.funct7 == F7_ALT && (bus.funct3 == F3_ADD || bus.funct3 == F3_SR))) begin
                    n_rd = alu_res;
                end else begin
                    n_ill = 1'b1;
                end
            end
            default: n_ill = 1'b1;
        endcase
    end

    // Operands widened to 2*XLEN so one unsigned multiply serves all four signedness modes.
    assign a_sgn    = (bus.funct3 == F3_MULH) || (bus.funct3 == F3_MULHSU);
    assign b_sgn    = (bus.funct3 == F3_MULH);
    assign a_ext    = {{XLEN{a_sgn & bus.rs1_val[XLEN-1]}}, bus.rs1_val};
    assign b_ext    = {{XLEN{b_sgn & bus.rs2_val[XLEN-1]}}, bus.rs2_val};
    assign mul_full = a_ext * b_ext;
    assign mul_sel  = (bus.funct3 == F3_MUL) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_v <= '0;
            for (int i = 0; i < MUL_LAT; i++) mul_pipe[i] <= '0;
        end else begin
            mul_v[0] <= accept && is_mul;
            if (accept && is_mul) mul_pipe[0] <= mul_sel;
            for (int i = 1; i < MUL_LAT; i++) begin
                mul_v[i]    <= mul_v[i-1];
                mul_pipe[i] <= mul_pipe[i-1];
            end
        end
    end

    div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && is_div),
        .dividend  (bus.rs1_val),
        .divisor   (bus.rs2_val),
        .signed_op (!bus.funct3[0]),
        .rem_sel   (bus.funct3[1]),
        .done      (div_done),
        .result    (div_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            rd_q        <= '0;
            addr_q      <= '0;
            taken_q     <= 1'b0;
            tgt_q       <= '0;
            ill_q       <= 1'b0;
            pc4_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        pc4_q <= pc4;
                        if (is_mul) begin
                            state_q     <= MUL;
                            out_valid_q <= 1'b0;
                        end else if (is_div) begin
                            state_q     <= DIV;
                            out_valid_q <= 1'b0;
                        end else begin
                            out_valid_q <= 1'b1;
                            rd_q        <= n_rd;
                            addr_q      <= n_addr;
                            taken_q     <= n_taken;
                            tgt_q       <= n_tgt;
                            ill_q       <= n_ill;
                        end
                    end else if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                MUL, DIV: begin
                    if ((state_q == MUL && mul_v[MUL_LAT-1]) || (state_q == DIV && div_done)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        rd_q        <= (state_q == MUL) ? mul_pipe[MUL_LAT-1] : div_result;
                        addr_q      <= '0;
                        taken_q     <= 1'b0;
                        tgt_q       <= pc4_q;
                        ill_q       <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.rd_data   = rd_q;
    assign bus.mem_addr  = addr_q;
    assign bus.br_taken  = taken_q;
    assign bus.br_target = tgt_q;
    assign bus.illegal   = ill_q;
    assign bus.busy      = (state_q == MUL) || (state_q == DIV);
endmodule

// File: tb/tb_exec_unit_m.sv
// tb/tb_exec_unit_m.sv - directed vector bench for exec_unit_m
module tb_exec_unit_m;
    import exec_unit_m_pkg::*;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;
    localparam int NV      = 21;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exec_unit_m_if #(.XLEN(XLEN)) bus ();

    exec_unit_m #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] pc, imm, rs1, rs2;
        logic [31:0] rd, addr;
        logic        taken;
        logic [31:0] tgt;
        logic        ill;
    } vec_t;

    vec_t vecs [NV];
    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic set_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] a, input logic [31:0] b);
        bus.opcode  = opc;
        bus.funct3  = f3;
        bus.funct7  = f7;
        bus.pc      = pc;
        bus.imm     = imm;
        bus.rs1_val = a;
        bus.rs2_val = b;
    endtask

    task automatic run_multi(input string nm, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cycles;
        set_op(OPC_OP, f3, F7_MEXT, 32'h0, 32'h0, a, b);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({nm, " busy"}, 32'(bus.busy), 32'd1);
        check({nm, " early out_valid"}, 32'(bus.out_valid), 32'd0);
        cycles = 0;
        while (!bus.out_valid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check({nm, " latency"}, 32'(cycles), 32'(lat));
        check({nm, " rd_data"}, bus.rd_data, exp);
        check({nm, " busy at done"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //             opc         f3      f7       pc            imm           rs1           rs2           rd            addr          tk    tgt           ill
        vecs[0]  = '{OPC_OP_IMM, 3'b000, 7'h00, 32'h0,        32'hFFFFFFF9, 32'd5,        32'h0,        32'hFFFFFFFE, 32'h0,        1'b0, 32'h4,        1'b0};
        vecs[1]  = '{OPC_BRANCH, 3'b100, 7'h00, 32'h100,      32'h20,       32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        1'b1, 32'h120,      1'b0};
        vecs[2]  = '{OPC_BRANCH, 3'b110, 7'h00, 32'h100,      32'h20,       32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        1'b0, 32'h104,      1'b0};
        vecs[3]  = '{OPC_OP,     3'b000, 7'h20, 32'h0,        32'h0,        32'd3,        32'd5,        32'hFFFFFFFE, 32'h0,        1'b0, 32'h4,        1'b0};
        vecs[4]  = '{OPC_OP,     3'b101, 7'h20, 32'h0,        32'h0,        32'h80000000, 32'h24,       32'hF8000000, 32'h0,        1'b0, 32'h4,        1'b0};
        vecs[5]  = '{OPC_OP_IMM, 3'b101, 7'h00, 32'h0,        32'h4,        32'h80000000, 32'h0,        32'h08000000, 32'h0,        1'b0, 32'h4,        1'b0};
        vecs[6]  = '{OPC_OP_IMM, 3'b010, 7'h00, 32'h0,        32'h1,        32'hFFFFFFFF, 32'h0,        32'h1,        32'h0,        1'b0, 32'h4,        1'b0};
        vecs[7]  = '{OPC_OP_IMM, 3'b011, 7'h00, 32'h0,        32'h1,        32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        1'b0, 32'h4,        1'b0};
        vecs[8]  = '{OPC_LUI,    3'b000, 7'h00, 32'h0,        32'h12345000, 32'h0,        32'h0,        32'h12345000, 32'h0,        1'b0, 32'h4,        1'b0};
        vecs[9]  = '{OPC_AUIPC,  3'b000, 7'h00, 32'h1000,     32'h2000,     32'h0,        32'h0,        32'h3000,     32'h0,        1'b0, 32'h1004,     1'b0};
        vecs[10] = '{OPC_JAL,    3'b000, 7'h00, 32'h200,      32'hFFFFFFF0, 32'h0,        32'h0,        32'h204,      32'h0,        1'b1, 32'h1F0,      1'b0};
        vecs[11] = '{OPC_JALR,   3'b000, 7'h00, 32'h40,       32'h4,        32'h301,      32'h0,        32'h44,       32'h0,        1'b1, 32'h304,      1'b0};
        vecs[12] = '{OPC_LOAD,   3'b010, 7'h00, 32'h0,        32'hFFFFFFFC, 32'h1000,     32'h0,        32'h0,        32'hFFC,      1'b0, 32'h4,        1'b0};
        vecs[13] = '{OPC_STORE,  3'b010, 7'h00, 32'h0,        32'h8,        32'h2000,     32'hDEADBEEF, 32'hDEADBEEF, 32'h2008,     1'b0, 32'h4,        1'b0};
        vecs[14] = '{7'h7F,      3'b000, 7'h00, 32'h10,       32'h0,        32'd5,        32'd6,        32'h0,        32'h0,        1'b0, 32'h14,       1'b1};
        vecs[15] = '{OPC_OP,     3'b001, 7'h20, 32'h0,        32'h0,        32'd1,        32'd1,        32'h0,        32'h0,        1'b0, 32'h4,        1'b1};
        vecs[16] = '{OPC_BRANCH, 3'b000, 7'h00, 32'h80,       32'hFFFFFF80, 32'd9,        32'd9,        32'h0,        32'h0,        1'b1, 32'h0,        1'b0};
        vecs[17] = '{OPC_OP,     3'b001, 7'h00, 32'h0,        32'h0,        32'd1,        32'h1F,       32'h80000000, 32'h0,        1'b0, 32'h4,        1'b0};
        vecs[18] = '{OPC_BRANCH, 3'b101, 7'h00, 32'h500,      32'h40,       32'h80000000, 32'h0,        32'h0,        32'h0,        1'b0, 32'h504,      1'b0};
        vecs[19] = '{OPC_OP,     3'b111, 7'h00, 32'h0,        32'h0,        32'hF0F0,     32'hFF00,     32'hF000,     32'h0,        1'b0, 32'h4,        1'b0};
        vecs[20] = '{OPC_JALR,   3'b001, 7'h00, 32'h40,       32'h4,        32'h301,      32'h0,        32'h0,        32'h0,        1'b0, 32'h44,       1'b1};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_op(7'h0, 3'h0, 7'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);

        check("reset in_ready", 32'(bus.in_ready), 32'd0);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset rd_data", bus.rd_data, 32'h0);
        check("reset mem_addr", bus.mem_addr, 32'h0);
        check("reset br_taken", 32'(bus.br_taken), 32'd0);
        check("reset br_target", bus.br_target, 32'h0);
        check("reset illegal", 32'(bus.illegal), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back single-cycle ops, one per clock.
        bus.out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            set_op(vecs[i].opc, vecs[i].f3, vecs[i].f7, vecs[i].pc, vecs[i].imm, vecs[i].rs1, vecs[i].rs2);
            bus.in_valid = 1'b1;
            #1;
            check($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'd1);
            @(negedge clk);
            check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("vec%0d rd_data", i), bus.rd_data, vecs[i].rd);
            check($sformatf("vec%0d mem_addr", i), bus.mem_addr, vecs[i].addr);
            check($sformatf("vec%0d br_taken", i), 32'(bus.br_taken), 32'(vecs[i].taken));
            check($sformatf("vec%0d br_target", i), bus.br_target, vecs[i].tgt);
            check($sformatf("vec%0d illegal", i), 32'(bus.illegal), 32'(vecs[i].ill));
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("drain out_valid", 32'(bus.out_valid), 32'd0);

        run_multi("mulh",    F3_MULH,   32'h80000000, 32'd2,        32'hFFFFFFFF, MUL_LAT);
        run_multi("mul",     F3_MUL,    32'd7,        32'd6,        32'd42,       MUL_LAT);
        run_multi("mulhu",   F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
        run_multi("mulhsu",  F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT);
        run_multi("div0",    F3_DIV,    32'd7,        32'd0,        32'hFFFFFFFF, XLEN + 1);
        run_multi("rem_ovf", F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        XLEN + 1);
        run_multi("div_ovf", F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, XLEN + 1);
        run_multi("div_neg", F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, XLEN + 1);
        run_multi("rem_neg", F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, XLEN + 1);
        run_multi("divu",    F3_DIVU,   32'd100,      32'd7,        32'd14,       XLEN + 1);
        run_multi("remu0",   F3_REMU,   32'd7,        32'd0,        32'd7,        XLEN + 1);

        // Output stall: result must hold and input must be refused until released.
        set_op(OPC_OP, F3_ADD, F7_BASE, 32'h0, 32'h0, 32'd3, 32'd4);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        set_op(OPC_OP, F3_ADD, F7_BASE, 32'h0, 32'h0, 32'd10, 32'd20);
        check("stall first rd_data", bus.rd_data, 32'd7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d rd_data", i), bus.rd_data, 32'd7);
            check($sformatf("stall%0d in_ready", i), 32'(bus.in_ready), 32'd0);
            check($sformatf("stall%0d out_valid", i), 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("release in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("release next rd_data", bus.rd_data, 32'd30);
        check("release next out_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);

        // Reset in the middle of a divide.
        set_op(OPC_OP, F3_DIV, F7_MEXT, 32'h0, 32'h0, 32'd100, 32'd7);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("middiv busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("middiv rst in_ready", 32'(bus.in_ready), 32'd0);
        check("middiv rst busy", 32'(bus.busy), 32'd0);
        check("middiv rst out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst in_ready", 32'(bus.in_ready), 32'd1);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (bus.out_valid) seen = 1;
            end
            check("aborted div no out_valid", 32'(seen), 32'd0);
        end
        set_op(OPC_OP, F3_ADD, F7_BASE, 32'h0, 32'h0, 32'd1, 32'd2);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("postrst add out_valid", 32'(bus.out_valid), 32'd1);
        check("postrst add rd_data", bus.rd_data, 32'd3);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
